// File: rtl/bpu_pcgen.sv
// bpu_pcgen: fetch PC generator with a direct-mapped BTB and 2-bit counters.
// Redirects on EX-stage mispredicts and keeps a saturating mispredict count.
module bpu_pcgen #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stallF,
  output logic [XLEN-1:0] pcF,
  output logic            predTakenF,
  output logic [XLEN-1:0] predTargetF,
  input  logic            resValidE,
  input  logic            resIsBranchE,
  input  logic            resTakenE,
  input  logic [XLEN-1:0] resPcE,
  input  logic [XLEN-1:0] resTargetE,
  input  logic            resPredTakenE,
  input  logic [XLEN-1:0] resPredTargetE,
  output logic            flushD,
  output logic            flushE,
  output logic [15:0]     mispredCnt
);
  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  logic            valid   [BTB_ENTRIES];
  logic [TAGW-1:0] tag     [BTB_ENTRIES];
  logic [XLEN-1:0] target  [BTB_ENTRIES];
  logic            is_jump [BTB_ENTRIES];
  logic [1:0]      ctr     [BTB_ENTRIES];
  logic [IDXW-1:0] f_idx, r_idx;
  logic [TAGW-1:0] f_tag, r_tag;
  logic            f_hit, r_hit, mispred;
  logic [XLEN-1:0] pc_next;
  assign f_idx = pcF[IDXW+1:2];
  assign f_tag = pcF[XLEN-1:IDXW+2];
  assign r_idx = resPcE[IDXW+1:2];
  assign r_tag = resPcE[XLEN-1:IDXW+2];
  assign f_hit = valid[f_idx] && tag[f_idx] == f_tag;
  assign r_hit = valid[r_idx] && tag[r_idx] == r_tag;
  assign predTakenF = rstn && f_hit && (is_jump[f_idx] || ctr[f_idx][1]);
  assign predTargetF = f_hit ? target[f_idx] : pcF + XLEN'(4);
  assign mispred = resValidE && ((resTakenE != resPredTakenE) ||
                                 (resTakenE && resTargetE != resPredTargetE));
  assign flushD = mispred;
  assign flushE = mispred;
  always_comb
    pc_next = mispred    ? (resTakenE ? resTargetE : resPcE + XLEN'(4)) :
              stallF     ? pcF :
              predTakenF ? predTargetF : pcF + XLEN'(4);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pcF <= RESET_PC;
      mispredCnt <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i] <= CNT_INIT;
      end
    end else begin
      pcF <= pc_next;
      if (mispred && mispredCnt != 16'hFFFF) mispredCnt <= mispredCnt + 16'd1;
      if (resValidE && r_hit) begin
        ctr[r_idx] <= resTakenE ? (ctr[r_idx] == 2'd3 ? 2'd3 : ctr[r_idx] + 2'd1)
                                : (ctr[r_idx] == 2'd0 ? 2'd0 : ctr[r_idx] - 2'd1);
        if (resTakenE) begin
          target[r_idx] <= resTargetE;
          is_jump[r_idx] <= !resIsBranchE;
        end
      end else if (resValidE && resTakenE) begin
        valid[r_idx] <= 1'b1;
        tag[r_idx] <= r_tag;
        target[r_idx] <= resTargetE;
        is_jump[r_idx] <= !resIsBranchE;
        ctr[r_idx] <= 2'b10;
      end
    end
endmodule

// File: tb/tb_bpu_pcgen.sv
// tb_bpu_pcgen: directed vectors with hand-computed expectations for bpu_pcgen.
module tb_bpu_pcgen;
  logic        clk = 1'b0;
  logic        rstn, stallF;
  logic [31:0] pcF, predTargetF;
  logic        predTakenF;
  logic        resValidE, resIsBranchE, resTakenE, resPredTakenE;
  logic [31:0] resPcE, resTargetE, resPredTargetE;
  logic        flushD, flushE;
  logic [15:0] mispredCnt;
  int checks = 0;
  int errors = 0;
  bpu_pcgen dut (
    .clk(clk), .rstn(rstn), .stallF(stallF), .pcF(pcF),
    .predTakenF(predTakenF), .predTargetF(predTargetF),
    .resValidE(resValidE), .resIsBranchE(resIsBranchE), .resTakenE(resTakenE),
    .resPcE(resPcE), .resTargetE(resTargetE), .resPredTakenE(resPredTakenE),
    .resPredTargetE(resPredTargetE), .flushD(flushD), .flushE(flushE),
    .mispredCnt(mispredCnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic res(input logic v, input logic br, input logic tk, input logic [31:0] pc,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    resValidE = v;
    resIsBranchE = br;
    resTakenE = tk;
    resPcE = pc;
    resTargetE = tgt;
    resPredTakenE = ptk;
    resPredTargetE = ptgt;
  endtask
  initial begin
    rstn = 1'b0;
    stallF = 1'b0;
    res(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_pc", pcF, 32'h0);
    check("rst_pt", {31'b0, predTakenF}, 0);
    check("rst_cnt", {16'b0, mispredCnt}, 0);
    @(negedge clk);
    rstn = 1'b1;
    check("seq0", pcF, 32'h0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("seq", pcF, 32'(4 * i));
      check("seq_pt", {31'b0, predTakenF}, 0);
    end
    // taken branch predicted not-taken: redirect and allocate
    res(1, 1, 1, 32'h10, 32'h40, 0, 0);
    #1;
    check("mp_flushD", {31'b0, flushD}, 1);
    check("mp_flushE", {31'b0, flushE}, 1);
    @(negedge clk);
    check("mp_pc", pcF, 32'h40);
    check("mp_cnt", {16'b0, mispredCnt}, 1);
    // not-taken mispredict at 0xC steers fetch to 0x10 without allocating
    res(1, 1, 0, 32'hC, 0, 1, 0);
    @(negedge clk);
    check("nt_pc", pcF, 32'h10);
    check("nt_cnt", {16'b0, mispredCnt}, 2);
    res(0, 0, 0, 0, 0, 0, 0);
    stallF = 1'b1;
    #1;
    check("hit_pt", {31'b0, predTakenF}, 1);
    check("hit_tgt", predTargetF, 32'h40);
    // correct not-taken: counter 2 -> 1, old contents visible this cycle
    res(1, 1, 0, 32'h10, 32'h0, 0, 0);
    #1;
    check("ok_flushD", {31'b0, flushD}, 0);
    check("old_pt", {31'b0, predTakenF}, 1);
    @(negedge clk);
    check("ctr1_pt", {31'b0, predTakenF}, 0);
    check("ctr1_tgt", predTargetF, 32'h40);
    check("stall_pc", pcF, 32'h10);
    check("ok_cnt", {16'b0, mispredCnt}, 2);
    for (int i = 0; i < 3; i++) begin
      res(1, 1, 1, 32'h10, 32'h40, 1, 32'h40);
      @(negedge clk);
      check("inc_pt", {31'b0, predTakenF}, 1);
    end
    res(1, 1, 0, 32'h10, 0, 0, 0);
    @(negedge clk);
    check("dec2_pt", {31'b0, predTakenF}, 1);
    res(1, 1, 0, 32'h10, 0, 0, 0);
    @(negedge clk);
    check("dec1_pt", {31'b0, predTakenF}, 0);
    // stalled mispredict still redirects; 0x50 aliases index 4 with another tag
    res(1, 1, 0, 32'h4C, 0, 1, 0);
    #1;
    check("st_flushE", {31'b0, flushE}, 1);
    @(negedge clk);
    check("alias_pc", pcF, 32'h50);
    check("alias_pt", {31'b0, predTakenF}, 0);
    check("alias_tgt", predTargetF, 32'h54);
    check("alias_cnt", {16'b0, mispredCnt}, 3);
    res(1, 0, 1, 32'h20, 32'h80, 0, 0);
    #1;
    check("jal_flushD", {31'b0, flushD}, 1);
    @(negedge clk);
    check("jal_pc", pcF, 32'h80);
    check("jal_cnt", {16'b0, mispredCnt}, 4);
    res(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("hold_pc", pcF, 32'h80);
    // jal resolving at the same index as the lookup: old (miss) result first
    res(1, 0, 1, 32'h80, 32'h200, 1, 32'h200);
    #1;
    check("twin_old_pt", {31'b0, predTakenF}, 0);
    check("twin_old_tgt", predTargetF, 32'h84);
    check("twin_flushD", {31'b0, flushD}, 0);
    @(negedge clk);
    res(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("twin_new_pt", {31'b0, predTakenF}, 1);
    check("twin_new_tgt", predTargetF, 32'h200);
    stallF = 1'b0;
    @(negedge clk);
    check("follow_pc", pcF, 32'h200);
    // resPcE+4 wraps to zero
    res(1, 1, 0, 32'hFFFF_FFFC, 0, 1, 0);
    @(negedge clk);
    check("wrap_pc", pcF, 32'h0);
    check("wrap_cnt", {16'b0, mispredCnt}, 5);
    res(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("after_wrap", pcF, 32'h4);
    // reset lands on an in-flight allocation, which must be dropped
    res(1, 1, 1, 32'h4, 32'h100, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_pc", pcF, 32'h0);
    check("mid_rst_cnt", {16'b0, mispredCnt}, 0);
    check("mid_rst_flushD", {31'b0, flushD}, 1);
    check("mid_rst_pt", {31'b0, predTakenF}, 0);
    @(negedge clk);
    res(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_pc", pcF, 32'h4);
    check("post_rst_pt", {31'b0, predTakenF}, 0);
    check("post_rst_tgt", predTargetF, 32'h8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpu_pcgen.md
BPU_PCGEN -- requirements
Module: bpu_pcgen

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/data width.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16: BTB/BHT depth, power of two, at least 2; IDXW = log2(BTB_ENTRIES).
REQ-003 SHALL have parameter RESET_PC, default 0: fetch address after reset.
REQ-004 SHALL have parameter CNT_INIT, default 2'b01: counter value after reset (weakly not-taken).
REQ-005 SHALL have ports:
- clk  in  1  clock, all state on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- stallF  in  1  hold the fetch PC.
- pcF  out  XLEN  current fetch PC.
- predTakenF  out  1  prediction for pcF.
- predTargetF  out  XLEN  predicted target for pcF.
- resValidE  in  1  an EX-stage control-flow instruction resolves this cycle.
- resIsBranchE  in  1  1 = conditional branch, 0 = jal/jalr.
- resTakenE  in  1  actual direction.
- resPcE  in  XLEN  PC of the resolving instruction.
- resTargetE  in  XLEN  actual target.
- resPredTakenE  in  1  prediction carried down the pipe.
- resPredTargetE  in  XLEN  predicted target carried down the pipe.
- flushD  out  1  kill ID.
- flushE  out  1  kill EX.
- mispredCnt  out  16  saturating mispredict count.

Function
REQ-006 SHALL index the BTB with pcF[IDXW+1:2] and tag it with pcF[XLEN-1:IDXW+2]; each entry holds valid, tag, target, isJump and a 2-bit counter.
REQ-007 SHALL compute hit = valid & tag match, combinationally; predTakenF = hit & (isJump | ctr[1]); predTargetF = entry target when hit, else pcF+4.
REQ-008 SHALL compute mispredict = resValidE & ((resTakenE != resPredTakenE) | (resTakenE & resTargetE != resPredTargetE)), combinationally.
REQ-009 SHALL drive flushD = flushE = mispredict, combinationally, in the same cycle.
REQ-010 SHALL load the next pcF by this priority: mispredict -> (resTakenE ? resTargetE : resPcE+4); else stallF -> hold; else predTakenF -> predTargetF; else pcF+4.
REQ-011 SHALL wrap all PC additions modulo 2^XLEN.
REQ-012 SHALL apply these BTB updates at the clock edge when resValidE and the entry at resPcE's index hits resPcE's tag:
- taken: counter saturating increment (max 3), target and isJump rewritten.
- not taken: counter saturating decrement (min 0).
REQ-013 SHALL, when resValidE and resTakenE and the entry misses, allocate or overwrite the entry: valid=1, tag, target=resTargetE, isJump=!resIsBranchE, counter=2'b10.
REQ-014 SHALL NOT allocate an entry for a not-taken resolution that misses.
REQ-015 SHALL return the pre-update contents when a lookup and an update hit the same index in one cycle; new contents are visible from the next cycle.
REQ-016 SHALL increment mispredCnt by 1 on each mispredict cycle and hold it at 16'hFFFF.
REQ-017 SHALL allow a stallF cycle to update BTB state; only pcF is held.

Reset
REQ-018 SHALL, while rstn is low, immediately set pcF=RESET_PC, clear all valid bits, set all counters to CNT_INIT, and set mispredCnt=0.
REQ-019 SHALL, while rstn is low, drive predTakenF=0; flushD and flushE follow REQ-009.
REQ-020 SHALL, on reset assertion mid-operation, discard any in-flight update.

Verification (XLEN=32, BTB_ENTRIES=16, RESET_PC=0)
REQ-021 Reset then release, no stall, resValidE=0 -> pcF 0x0, 0x4, 0x8, 0xC; predTakenF=0; mispredCnt=0.
REQ-022 Resolve branch pc 0x10 taken to 0x40 with predicted not-taken -> flushD=flushE=1 that cycle; next pcF=0x40; mispredCnt=1. Later pcF=0x10 -> predTakenF=1, predTargetF=0x40.
REQ-023 Entry 0x10 at counter 2, one not-taken resolution -> counter 1; pcF=0x10 gives predTakenF=0. A correct not-taken resolution -> flushD=0.
REQ-024 Three taken resolutions of 0x10, then one not-taken -> counter 3 then 2; prediction stays taken.
REQ-025 Entry at 0x10, lookup pcF=0x50 (same index 4, different tag) -> predTakenF=0, predTargetF=0x54.
REQ-026 stallF=1 with mispredict to 0x80 -> next pcF=0x80. stallF=1 alone -> pcF unchanged. Twin jal at pcF and resPcE with the same index -> lookup returns old entry.
